horizontal_rom_seq: RTL and testbench
=====================================

# horizontal_rom_seq

Read sequencer that sits directly upstream of the horizontal twiddle datapath. On a start pulse it walks every stage of the transform and issues twiddle-ROM addresses with an active-low chip enable. It drives the `state`, `stage_counter` and `CEN` inputs that the horizontal twiddle top and its ROM bank consume. Its outputs define the exact cycle on which each twiddle word is requested.

## Interface
Parameters:
- `S_WIDTH`, 4: width of the `state` output.
- `DC_WIDTH`, 13: MSB index of the data counter; `data_cnt` is `[DC_WIDTH:0]`.
- `DCNT_BP4`, 10: log2 of words per stage; the address is `[DCNT_BP4-1:0]`.
- `STAGE_NUM`, 4: number of stages walked per run (1..16).
- `GAP_CYCLES`, 4: idle cycles between stages, for pipeline flush (1..15).

Ports (all outputs registered):
- `clk`, in, 1: the single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous and active-high (asserted when 1).
- `start`, in, 1: run request, sampled in IDLE only.
- `stall`, in, 1: freeze request (see Configuration).
- `state`, out, `S_WIDTH`: FSM state code.
- `stage_counter`, out, `[DC_WIDTH:DCNT_BP4]` (4 bits): current stage.
- `rom_addr`, out, `DCNT_BP4`: ROM word address.
- `data_cnt`, out, `DC_WIDTH+1`: equal to `{stage_counter, rom_addr}`.
- `CEN`, out, 1: ROM enable, active low.
- `busy`, out, 1: high in RUN and GAP.
- `done`, out, 1: one-cycle pulse at the end of a run.

## Operation
State codes:
- IDLE=0: `CEN`=1, counters 0, waits for `start`.
- RUN=1: `CEN`=0.
- GAP=2: `CEN`=1, address held at 0.
- DONE=3: `done`=1, `CEN`=1.

Transitions:
- IDLE + `start` → RUN with `stage_counter`=0 and `rom_addr`=0.
- RUN, not stalled: `rom_addr`+1 each cycle.
- RUN at `rom_addr`=2^DCNT_BP4−1:
  - if `stage_counter`=STAGE_NUM−1 → DONE;
  - else → GAP, and the gap counter loads GAP_CYCLES−1.
- GAP: the gap counter decrements. At 0 → RUN with `stage_counter`+1 and `rom_addr`=0.
- DONE → IDLE unconditionally on the next cycle. Counters clear.

Stall in RUN:
- `CEN`=1; `rom_addr` and `stage_counter` hold.
- On release the run resumes at the held address, so no address is skipped or repeated.

Stall in GAP:
- The gap counter holds.

Other rules:
- `start` while busy or in DONE is ignored. It is not queued.
- `start` and `stall` together in IDLE: go to RUN. The stall then takes effect in the first RUN cycle, so `CEN` stays 1.
- Address wrap: `rom_addr` wraps to 0 only through GAP or DONE. It never wraps while staying in RUN.
- `stage_counter` never exceeds STAGE_NUM−1.
- Reset (any state, including mid-run) → next edge gives IDLE, all counters 0, `CEN`=1, `busy`=0, `done`=0. No partial run resumes.

## Timing
- Reset values: `state`=0, `stage_counter`=0, `rom_addr`=0, `data_cnt`=0, `CEN`=1, `busy`=0, `done`=0.
- Launch: `start` sampled high at edge t → at t+1, `CEN`=0 and `rom_addr`=0. ROM data for that address is valid downstream at t+2.
- Run length with no stalls, from the first `CEN`=0 to `done`: STAGE_NUM·2^DCNT_BP4 + (STAGE_NUM−1)·GAP_CYCLES cycles. `done` is high in the cycle after the last read.
- Stall response: `stall` high at edge t → `CEN`=1 from t+1. Each stalled cycle adds exactly one cycle to the run.
- `CEN`, `rom_addr` and `stage_counter` always change on the same edge. They never skew by a cycle.

## Configuration
- Macro `HORIZONTAL_SEQ_STALL_EN`.
- Defined: `stall` behaves as described above.
- Undefined: the `stall` port is still present but ignored, as if tied 0. Runs always take the fixed length.

## Test plan
Parameters for all scenarios: DCNT_BP4=2 (4 words/stage), STAGE_NUM=3, GAP_CYCLES=2.

1. **Reset then idle.** `rst_n`=1 for 2 cycles, then 0 with no `start` → all outputs at reset values; `CEN` stays 1.
2. **Full run.** `start` pulse at t → `CEN`=0 at t+1..t+4 with `rom_addr` 0,1,2,3 and `stage_counter`=0. Then GAP at t+5..t+6 (`CEN`=1). Stage 1 at t+7..t+10, GAP t+11..t+12, stage 2 at t+13..t+16. `done`=1 at t+17; IDLE at t+18.
3. **Stall.** With the macro defined, `stall` high for 3 cycles while `rom_addr`=2 in stage 1 → `CEN`=1 and the address holds at 2 for those 3 cycles. Then addresses 2,3 continue; `done` arrives 3 cycles later than in scenario 2.
4. **Stall ignored.** Same stimulus as scenario 3 with the macro undefined → timing identical to scenario 2.
5. **Start while busy.** `start` pulsed at every cycle t+3..t+10 during a run → exactly one run and one `done` pulse. `data_cnt` equals `{stage_counter, rom_addr}` every cycle.
6. **Reset mid-run.** `rst_n`=1 at stage 1, `rom_addr`=1 → next cycle IDLE, `CEN`=1, counters 0, no `done`. A new `start` gives a full scenario-2 sequence.

Source files
------------

// File: rtl/horizontal_rom_seq.sv
// horizontal_rom_seq
// Read sequencer that feeds the horizontal twiddle datapath. A start pulse
// launches a walk over STAGE_NUM stages. Each stage issues 2^DCNT_BP4 ROM reads
// with an active-low chip enable. Consecutive stages are separated by
// GAP_CYCLES idle cycles so the downstream pipeline can flush.
// Optional feature: define HORIZONTAL_SEQ_STALL_EN to honour the stall input.
// When the macro is not defined, stall is ignored.
// Every output is driven straight from a register.
module horizontal_rom_seq #(
   parameter int S_WIDTH    = 4,
   parameter int DC_WIDTH   = 13,
   parameter int DCNT_BP4   = 10,
   parameter int STAGE_NUM  = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       stall,
   output logic [S_WIDTH-1:0]         state,
   output logic [DC_WIDTH:DCNT_BP4]   stage_counter,
   output logic [DCNT_BP4-1:0]        rom_addr,
   output logic [DC_WIDTH:0]          data_cnt,
   output logic                       CEN,
   output logic                       busy,
   output logic                       done
);

   localparam int SC_W = DC_WIDTH - DCNT_BP4 + 1;

   localparam logic [DCNT_BP4-1:0] ADDR_MAX   = {DCNT_BP4{1'b1}};
   localparam logic [DCNT_BP4-1:0] ADDR_ZERO  = {DCNT_BP4{1'b0}};
   localparam logic [DCNT_BP4-1:0] ADDR_INC   = DCNT_BP4'(32'd1);
   localparam logic [SC_W-1:0]     STAGE_ZERO = {SC_W{1'b0}};
   localparam logic [SC_W-1:0]     STAGE_INC  = SC_W'(32'd1);
   localparam logic [SC_W-1:0]     STAGE_LAST = SC_W'(STAGE_NUM - 1);
   localparam logic [3:0]          GAP_LOAD   = 4'(GAP_CYCLES - 1);

   typedef enum logic [S_WIDTH-1:0] {
      ST_IDLE = S_WIDTH'(32'd0),
      ST_RUN  = S_WIDTH'(32'd1),
      ST_GAP  = S_WIDTH'(32'd2),
      ST_DONE = S_WIDTH'(32'd3)
   } seq_state_t;

   seq_state_t           state_r, state_s;
   logic [SC_W-1:0]      stage_r, stage_s;
   logic [DCNT_BP4-1:0]  addr_r, addr_s;
   logic [3:0]           gap_r, gap_s;
   logic                 cen_r, cen_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic                 stall_eff_s;

`ifdef HORIZONTAL_SEQ_STALL_EN
   assign stall_eff_s = stall;
`else
   assign stall_eff_s = stall & 1'b0;
`endif

   // Next-state, counter and output decode. In RUN, cen_r==0 marks a cycle
   // in which the current address is actually read. Only such a cycle may
   // advance the address. A stalled cycle (cen_r==1) keeps the unread address.
   always_comb begin
      state_s = state_r;
      stage_s = stage_r;
      addr_s  = addr_r;
      gap_s   = gap_r;
      cen_s   = 1'b1;
      case (state_r)
         ST_IDLE: begin
            stage_s = STAGE_ZERO;
            addr_s  = ADDR_ZERO;
            gap_s   = 4'd0;
            if (start) begin
               state_s = ST_RUN;
               cen_s   = stall_eff_s;
            end else begin
               cen_s   = 1'b1;
            end
         end
         ST_RUN: begin
            if (!cen_r) begin
               if (addr_r == ADDR_MAX) begin
                  addr_s = ADDR_ZERO;
                  cen_s  = 1'b1;
                  if (stage_r == STAGE_LAST) begin
                     state_s = ST_DONE;
                  end else begin
                     state_s = ST_GAP;
                     gap_s   = GAP_LOAD;
                  end
               end else begin
                  addr_s = addr_r + ADDR_INC;
                  cen_s  = stall_eff_s;
               end
            end else begin
               cen_s = stall_eff_s;
            end
         end
         ST_GAP: begin
            if (stall_eff_s) begin
               cen_s = 1'b1;
            end else if (gap_r == 4'd0) begin
               state_s = ST_RUN;
               stage_s = stage_r + STAGE_INC;
               addr_s  = ADDR_ZERO;
               cen_s   = 1'b0;
            end else begin
               gap_s   = gap_r - 4'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            stage_s = STAGE_ZERO;
            addr_s  = ADDR_ZERO;
            gap_s   = 4'd0;
         end
         default: begin
            state_s = ST_IDLE;
            stage_s = STAGE_ZERO;
            addr_s  = ADDR_ZERO;
            gap_s   = 4'd0;
         end
      endcase
      busy_s = (state_s == ST_RUN) || (state_s == ST_GAP);
      done_s = (state_s == ST_DONE);
   end

   // State, counters and registered outputs. Reset is synchronous and high-true.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_r <= ST_IDLE;
         stage_r <= STAGE_ZERO;
         addr_r  <= ADDR_ZERO;
         gap_r   <= 4'd0;
         cen_r   <= 1'b1;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         stage_r <= stage_s;
         addr_r  <= addr_s;
         gap_r   <= gap_s;
         cen_r   <= cen_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign state         = state_r;
   assign stage_counter = stage_r;
   assign rom_addr      = addr_r;
   assign data_cnt      = {stage_r, addr_r};
   assign CEN           = cen_r;
   assign busy          = busy_r;
   assign done          = done_r;

endmodule

// File: tb/tb_horizontal_rom_seq.sv
// Testbench for horizontal_rom_seq: 4 words/stage, 3 stages, 2 gap cycles.
// Expected outputs come from a schedule model. A run is a flat list of
// read slots and gap slots, and a pointer walks that list.
module tb_horizontal_rom_seq;

   localparam int S_WIDTH    = 4;
   localparam int DC_WIDTH   = 5;
   localparam int DCNT_BP4   = 2;
   localparam int STAGE_NUM  = 3;
   localparam int GAP_CYCLES = 2;
   localparam int WORDS      = 1 << DCNT_BP4;

`ifdef HORIZONTAL_SEQ_STALL_EN
   localparam int STALL_DONE_AT = 20;
`else
   localparam int STALL_DONE_AT = 17;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start;
   logic                     stall;
   logic [S_WIDTH-1:0]       state;
   logic [DC_WIDTH:DCNT_BP4] stage_counter;
   logic [DCNT_BP4-1:0]      rom_addr;
   logic [DC_WIDTH:0]        data_cnt;
   logic                     CEN;
   logic                     busy;
   logic                     done;

   horizontal_rom_seq #(
      .S_WIDTH(S_WIDTH), .DC_WIDTH(DC_WIDTH), .DCNT_BP4(DCNT_BP4),
      .STAGE_NUM(STAGE_NUM), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
      .state(state), .stage_counter(stage_counter), .rom_addr(rom_addr),
      .data_cnt(data_cnt), .CEN(CEN), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;
   int dn     = 0;

   // Run schedule: kind 0 = read (stage, addr), kind 1 = gap slot of a stage.
   int sch_kind[$];
   int sch_stage[$];
   int sch_addr[$];

   // Model: mode 0 idle, 1 active, 2 done.
   int m_mode = 0;
   int m_idx  = 0;
   bit m_held = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic build_schedule();
      for (int s = 0; s < STAGE_NUM; s++) begin
         for (int a = 0; a < WORDS; a++) begin
            sch_kind.push_back(0); sch_stage.push_back(s); sch_addr.push_back(a);
         end
         if (s < STAGE_NUM - 1) begin
            for (int g = 0; g < GAP_CYCLES; g++) begin
               sch_kind.push_back(1); sch_stage.push_back(s); sch_addr.push_back(0);
            end
         end
      end
   endtask

   task automatic model_step();
      bit se;
`ifdef HORIZONTAL_SEQ_STALL_EN
      se = stall;
`else
      se = 1'b0;
`endif
      if (rst_n) begin
         m_mode = 0;
      end else begin
         case (m_mode)
            0: if (start) begin m_mode = 1; m_idx = 0; m_held = se; end
            1: begin
               if (sch_kind[m_idx] == 0 && m_held) begin
                  m_held = se;
               end else if (sch_kind[m_idx] == 1 && se) begin
                  m_held = 1'b0;
               end else begin
                  m_idx++;
                  if (m_idx == sch_kind.size()) m_mode = 2;
                  else m_held = (sch_kind[m_idx] == 0) && se;
               end
            end
            default: m_mode = 0;
         endcase
      end
   endtask

   task automatic check_all();
      int e_st, e_cen, e_a, e_s, e_busy, e_done;
      e_st = 0; e_cen = 1; e_a = 0; e_s = 0; e_busy = 0; e_done = 0;
      if (m_mode == 1) begin
         e_busy = 1;
         e_s    = sch_stage[m_idx];
         if (sch_kind[m_idx] == 0) begin
            e_st = 1; e_cen = m_held ? 1 : 0; e_a = sch_addr[m_idx];
         end else begin
            e_st = 2;
         end
      end else if (m_mode == 2) begin
         e_st = 3; e_done = 1;
      end
      chk("state", 32'(state), 32'(e_st));
      chk("CEN",   32'(CEN),   32'(e_cen));
      chk("busy",  32'(busy),  32'(e_busy));
      chk("done",  32'(done),  32'(e_done));
      if (m_mode != 2) begin
         chk("rom_addr",      32'(rom_addr),      32'(e_a));
         chk("stage_counter", 32'(stage_counter), 32'(e_s));
         chk("data_cnt",      32'(data_cnt),      32'(e_s * WORDS + e_a));
      end else begin
         chk("data_cnt_concat", 32'(data_cnt), 32'({stage_counter, rom_addr}));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (done === 1'b1) dn++;
   endtask

   initial begin
      int n;
      build_schedule();
      rst_n = 1'b1; start = 1'b0; stall = 1'b0;

      // Reset then idle
      cycle(); cycle();
      rst_n = 1'b0;
      repeat (3) cycle();

      // Full run: done lands 17 cycles after the start edge
      start = 1'b1; cycle(); start = 1'b0; n = 1;
      while (done !== 1'b1 && n < 100) begin cycle(); n++; end
      chk("full_run_done_at", 32'(n), 32'd17);
      repeat (3) cycle();

      // Stall for 3 cycles so stage 1 address 2 is held unread
      start = 1'b1; cycle(); start = 1'b0; n = 1;
      while (n < 8) begin cycle(); n++; end
      stall = 1'b1;
      repeat (3) begin cycle(); n++; end
      stall = 1'b0;
      while (done !== 1'b1 && n < 100) begin cycle(); n++; end
      chk("stall_run_done_at", 32'(n), 32'(STALL_DONE_AT));
      repeat (3) cycle();

      // Start pulsed while busy: one run, one done
      dn = 0;
      start = 1'b1; cycle(); start = 1'b0; cycle();
      start = 1'b1;
      repeat (8) cycle();
      start = 1'b0;
      repeat (25) cycle();
      chk("busy_start_done_pulses", 32'(dn), 32'd1);

      // Reset mid-run at stage 1 address 1, then a clean run
      dn = 0;
      start = 1'b1; cycle(); start = 1'b0; n = 1;
      while (n < 8) begin cycle(); n++; end
      rst_n = 1'b1; cycle(); rst_n = 1'b0;
      repeat (4) cycle();
      chk("reset_mid_run_no_done", 32'(dn), 32'd0);
      start = 1'b1; cycle(); start = 1'b0; n = 1;
      while (done !== 1'b1 && n < 100) begin cycle(); n++; end
      chk("rerun_done_at", 32'(n), 32'd17);
      repeat (2) cycle();

      // Randomized start/stall/reset traffic against the model
      repeat (900) begin
         start = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 149) == 0);
         cycle();
      end
      start = 1'b0; stall = 1'b0; rst_n = 1'b0;
      repeat (40) cycle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
